// File: rtl/poly_operand_sequencer.sv
// Operand-set FIFO and start sequencer feeding the quadratic evaluator.
// Pops one {x,a,b,c} set at a time, pulses enable, then waits for valid and ready.
module poly_operand_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int GAP    = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_push,
  input  logic [7:0]        in_x,
  input  logic [15:0]       in_a,
  input  logic [15:0]       in_b,
  input  logic [15:0]       in_c,
  output logic              in_full,
  output logic [ADDR_W:0]   in_count,
  output logic              overflow,
  output logic [7:0]        x,
  output logic [15:0]       a,
  output logic [15:0]       b,
  output logic [15:0]       c,
  output logic              enable,
  input  logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic [15:0]       issued_count
);

  typedef enum logic [2:0] {
    S_GAP_WAIT,
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_VALID,
    S_WAIT_READY
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [55:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_overflow;
  logic [7:0]          r_gap_cnt;
  logic [7:0]          r_x;
  logic [15:0]         r_a;
  logic [15:0]         r_b;
  logic [15:0]         r_c;
  logic [15:0]         r_issued;

  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_gap_done;
  logic [55:0]         w_head;

  assign w_full = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
  assign w_push = in_push && (!w_full || w_pop);
  assign w_head = r_mem[r_rd_ptr];

  // The IDLE decision cycle is the last of the GAP idle cycles, so GAP_WAIT
  // itself lasts GAP-1 cycles (one cycle minimum).
  assign w_gap_done = ({2'b00, r_gap_cnt} + 10'd2) >= 10'(GAP);

  // NOTE: storage array has no reset; occupancy is tracked by pointers and count,
  // so stale entries are never observed and the array can map to plain RAM.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_x, in_a, in_b, in_c};
    end
  end

  // NOTE: every sequential assignment is non-blocking so all registers update
  // together from the values present before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (in_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_GAP_WAIT;
      r_gap_cnt <= '0;
      r_x       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_issued  <= '0;
    end else begin
      r_state   <= w_next;
      r_gap_cnt <= (r_state == S_GAP_WAIT) ? r_gap_cnt + 8'd1 : 8'd0;
      if (w_pop) begin
        r_x <= w_head[55:48];
        r_a <= w_head[47:32];
        r_b <= w_head[31:16];
        r_c <= w_head[15:0];
      end
      if (r_state == S_ISSUE) r_issued <= r_issued + 16'd1;
    end
  end

  // NOTE: defaults first, so no path through the case leaves a signal unassigned
  // and no latch is inferred.
  always_comb begin
    w_next = r_state;
    enable = 1'b0;
    busy   = 1'b0;
    case (r_state)
      S_GAP_WAIT:   if (w_gap_done) w_next = S_IDLE;
      S_IDLE:       if (r_count != '0) w_next = S_LOAD;
      S_LOAD: begin
        busy   = 1'b1;
        w_next = S_ISSUE;
      end
      S_ISSUE: begin
        busy   = 1'b1;
        enable = 1'b1;
        w_next = S_WAIT_VALID;
      end
      S_WAIT_VALID: begin
        busy = 1'b1;
        if (valid) w_next = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        busy = 1'b1;
        if (ready) w_next = S_GAP_WAIT;
      end
      default:      w_next = S_GAP_WAIT;
    endcase
  end

  assign in_full      = w_full;
  assign in_count     = r_count;
  assign overflow     = r_overflow;
  assign x            = r_x;
  assign a            = r_a;
  assign b            = r_b;
  assign c            = r_c;
  assign issued_count = r_issued;

endmodule

// File: tb/tb_poly_operand_sequencer.sv
// Directed bench for poly_operand_sequencer with a simple evaluator model
// (valid 6 cycles after enable, ready 2 cycles after valid, optional hold).
module tb_poly_operand_sequencer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int GAP    = 5;
  localparam int SPACING = 8 + GAP + 2;   // enable-to-ready in the model, then ready-to-enable

  logic              clock;
  logic              reset;
  logic              in_push;
  logic [7:0]        in_x;
  logic [15:0]       in_a;
  logic [15:0]       in_b;
  logic [15:0]       in_c;
  logic              in_full;
  logic [ADDR_W:0]   in_count;
  logic              overflow;
  logic [7:0]        x;
  logic [15:0]       a;
  logic [15:0]       b;
  logic [15:0]       c;
  logic              enable;
  logic              valid;
  logic              ready;
  logic              busy;
  logic [15:0]       issued_count;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ready_cyc = -1000;
  logic        ev_hold = 1'b0;
  logic [55:0] pv;

  poly_operand_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP(GAP)) dut (
    .clock(clock), .reset(reset), .in_push(in_push),
    .in_x(in_x), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_full(in_full), .in_count(in_count), .overflow(overflow),
    .x(x), .a(a), .b(b), .c(c), .enable(enable),
    .valid(valid), .ready(ready), .busy(busy), .issued_count(issued_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Evaluator model
  initial begin
    valid = 1'b0;
    ready = 1'b1;
    forever begin
      @(negedge clock);
      if (enable === 1'b1) begin
        ready = 1'b0;
        repeat (6) @(negedge clock);
        while (ev_hold) @(negedge clock);
        valid = 1'b1;
        @(negedge clock);
        valid = 1'b0;
        @(negedge clock);
        ready = 1'b1;
        ready_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [55:0] mk(input int k);
    mk = {8'(k * 3 + 1), 16'(k * 1000 - 5000), 16'(-k * 37), 16'(k + 'h1200)};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    in_push = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic push_set(input logic [55:0] d);
    in_push = 1'b1;
    {in_x, in_a, in_b, in_c} = d;
    @(negedge clock);
    in_push = 1'b0;
  endtask

  // Waits for the next enable pulse; pv holds the operands one cycle earlier.
  task automatic wait_enable(output int ecyc, output logic ok);
    int n;
    ok = 1'b0;
    ecyc = 0;
    n = 0;
    while (!ok && n < 200) begin
      pv = {x, a, b, c};
      @(negedge clock);
      n++;
      if (enable === 1'b1) begin
        ok = 1'b1;
        ecyc = cyc;
      end
    end
  endtask

  task automatic wait_done();
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clock);
      n++;
      done = (busy === 1'b0) && (ready === 1'b1) && (valid === 1'b0);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: transaction still busy after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({enable, busy, in_full, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {enable, busy, in_full, overflow});
    end
    checks++;
    if (in_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", in_count);
    end
    checks++;
    if ({x, a, b, c} !== 56'h0) begin
      errors++;
      $display("FAIL reset_operands: got %h expected 0", {x, a, b, c});
    end
    checks++;
    if (issued_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_issued: got %0d expected 0", issued_count);
    end
  endtask

  task automatic test_first_issue();
    int c1, ecyc;
    logic ok;
    logic [55:0] exp_d;
    exp_d = {8'd2, 16'd1, 16'd3, 16'd4};
    do_reset();
    c1 = cyc;
    push_set(exp_d);
    checks++;
    if (in_count !== 4'd1) begin
      errors++;
      $display("FAIL first_count: got %0d expected 1", in_count);
    end
    wait_enable(ecyc, ok);
    checks++;
    if (ok !== 1'b1 || ecyc !== c1 + 6) begin
      errors++;
      $display("FAIL first_latency: got cycle %0d (seen %b) expected cycle 7", ecyc - c1 + 1, ok);
    end
    checks++;
    if ({x, a, b, c} !== exp_d || pv !== exp_d) begin
      errors++;
      $display("FAIL first_operands: got %h prev %h expected %h", {x, a, b, c}, pv, exp_d);
    end
    @(negedge clock);
    checks++;
    if (enable !== 1'b0 || issued_count !== 16'd1) begin
      errors++;
      $display("FAIL first_pulse: enable %b issued %0d expected 0 and 1", enable, issued_count);
    end
    wait_done();
  endtask

  task automatic test_three_sets();
    int ecyc, prev;
    logic ok;
    do_reset();
    for (int k = 1; k <= 3; k++) push_set(mk(k));
    prev = 0;
    for (int k = 1; k <= 3; k++) begin
      wait_enable(ecyc, ok);
      checks++;
      if (ok !== 1'b1 || {x, a, b, c} !== mk(k)) begin
        errors++;
        $display("FAIL three_operands[%0d]: got %h (seen %b) expected %h", k, {x, a, b, c}, ok, mk(k));
      end
      if (k > 1) begin
        checks++;
        if (ecyc - prev !== SPACING) begin
          errors++;
          $display("FAIL three_spacing[%0d]: got %0d expected %0d", k, ecyc - prev, SPACING);
        end
      end
      prev = ecyc;
    end
    wait_done();
    checks++;
    if (issued_count !== 16'd3 || in_count !== '0) begin
      errors++;
      $display("FAIL three_final: issued %0d count %0d expected 3 and 0", issued_count, in_count);
    end
  endtask

  task automatic test_overflow();
    int ecyc;
    logic ok;
    ev_hold = 1'b1;
    do_reset();
    for (int k = 1; k <= 9; k++) push_set(mk(k));
    checks++;
    if (in_full !== 1'b1 || in_count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: full %b count %0d ovf %b expected 1 8 0", in_full, in_count, overflow);
    end
    push_set(mk(10));
    checks++;
    if (overflow !== 1'b1 || in_count !== 4'd8) begin
      errors++;
      $display("FAIL ovf_drop: ovf %b count %0d expected 1 8", overflow, in_count);
    end
    ev_hold = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      wait_enable(ecyc, ok);
      checks++;
      if (ok !== 1'b1 || {x, a, b, c} !== mk(k)) begin
        errors++;
        $display("FAIL ovf_order[%0d]: got %h (seen %b) expected %h", k, {x, a, b, c}, ok, mk(k));
      end
    end
    wait_enable(ecyc, ok);
    checks++;
    if (ok !== 1'b0 || in_count !== '0 || issued_count !== 16'd9) begin
      errors++;
      $display("FAIL ovf_dropped_issued: extra enable %b count %0d issued %0d expected 0 0 9",
               ok, in_count, issued_count);
    end
    wait_done();
  endtask

  task automatic test_push_full_pop();
    int ecyc, n;
    logic ok;
    ev_hold = 1'b1;
    do_reset();
    for (int k = 1; k <= 9; k++) push_set(mk(k));
    checks++;
    if (in_full !== 1'b1 || in_count !== 4'd8) begin
      errors++;
      $display("FAIL pfp_full: full %b count %0d expected 1 8", in_full, in_count);
    end
    ready_cyc = -1000;
    ev_hold = 1'b0;
    n = 0;
    while (cyc != ready_cyc + GAP && n < 100) begin
      @(negedge clock);
      n++;
    end
    push_set(mk(10));
    checks++;
    if (in_count !== 4'd8 || overflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pfp_push_pop: count %0d ovf %b busy %b expected 8 0 1", in_count, overflow, busy);
    end
    for (int k = 2; k <= 10; k++) begin
      wait_enable(ecyc, ok);
      checks++;
      if (ok !== 1'b1 || {x, a, b, c} !== mk(k)) begin
        errors++;
        $display("FAIL pfp_order[%0d]: got %h (seen %b) expected %h", k, {x, a, b, c}, ok, mk(k));
      end
    end
    wait_done();
    checks++;
    if (issued_count !== 16'd10 || in_count !== '0) begin
      errors++;
      $display("FAIL pfp_final: issued %0d count %0d expected 10 0", issued_count, in_count);
    end
  endtask

  task automatic test_reset_mid();
    int ecyc;
    logic ok;
    ev_hold = 1'b1;
    do_reset();
    for (int k = 1; k <= 4; k++) push_set(mk(k + 20));
    wait_enable(ecyc, ok);
    repeat (3) @(negedge clock);
    checks++;
    if (ok !== 1'b1 || busy !== 1'b1 || in_count !== 4'd3) begin
      errors++;
      $display("FAIL mid_before: seen %b busy %b count %0d expected 1 1 3", ok, busy, in_count);
    end
    do_reset();
    checks++;
    if ({enable, busy} !== 2'b00 || in_count !== '0 || {x, a, b, c} !== 56'h0 || issued_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: en %b busy %b count %0d ops %h issued %0d expected all 0",
               enable, busy, in_count, {x, a, b, c}, issued_count);
    end
    ev_hold = 1'b0;
    wait_enable(ecyc, ok);
    checks++;
    if (ok !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_issue: got enable at cycle %0d expected none", ecyc);
    end
  endtask

  task automatic test_negative();
    int ecyc;
    logic ok;
    do_reset();
    push_set({8'(-128), 16'(-32768), 16'(32767), 16'(-1)});
    wait_enable(ecyc, ok);
    checks++;
    if (ok !== 1'b1 || {x, a, b, c} !== {8'h80, 16'h8000, 16'h7FFF, 16'hFFFF}) begin
      errors++;
      $display("FAIL negative_operands: got %h (seen %b) expected 8080007fffffff", {x, a, b, c}, ok);
    end
    wait_done();
  endtask

  initial begin
    reset   = 1'b1;
    in_push = 1'b0;
    in_x    = '0;
    in_a    = '0;
    in_b    = '0;
    in_c    = '0;
    test_reset();
    test_first_issue();
    test_three_sets();
    test_overflow();
    test_push_full_pop();
    test_reset_mid();
    test_negative();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
